// File: rtl/string_hw_pkg.sv
// Shared definitions for the string accelerator Avalon-MM front end.
//   - accelerator function codes and the highest legal code
//   - register word offsets, CTRL bit positions, STATUS bit positions
//   - FSM state and address-region enums
//   - NOT_FOUND: value the accelerator reports for a failed SEARCH
package string_hw_pkg;

  typedef enum logic [3:0] {
    FN_CMP    = 4'd0,
    FN_UPPER  = 4'd1,
    FN_LOWER  = 4'd2,
    FN_REV    = 4'd3,
    FN_SEARCH = 4'd4
  } func_t;

  localparam logic [3:0] MAX_FUNC = FN_SEARCH;

  localparam int unsigned NOT_FOUND = 256;

  // Word offsets inside the register region
  localparam int unsigned REG_CTRL   = 0;
  localparam int unsigned REG_CMD    = 1;
  localparam int unsigned REG_STATUS = 2;
  localparam int unsigned REG_RSVD   = 3;

  // CTRL bits
  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;
  localparam int unsigned CTRL_CLR    = 2;

  // STATUS bits
  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_DONE      = 1;
  localparam int unsigned STAT_BAD_INDEX = 2;
  localparam int unsigned STAT_TIMEOUT   = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RELEASE
  } state_t;

  // The two top address bits select one of four MAX_BLOCKS-word regions
  typedef enum logic [1:0] {
    RGN_REGS = 2'd0,
    RGN_A    = 2'd1,
    RGN_B    = 2'd2,
    RGN_R    = 2'd3
  } region_t;

endpackage

// File: rtl/string_hw_avalon_ctrl_if.sv
// Avalon-MM slave bus bundle for string_hw_avalon_ctrl.
//   avs_address    word address (AW bits)
//   avs_write      write strobe, avs_writedata / avs_byteenable qualify it
//   avs_read       read strobe
//   avs_readdata   read data, valid one cycle after avs_read
// AW must equal $clog2(MAX_BLOCKS)+2 of the attached controller.
interface string_hw_avalon_ctrl_if #(
  parameter int unsigned AW = 5
) ();

  logic [AW-1:0] avs_address;
  logic          avs_write;
  logic [31:0]   avs_writedata;
  logic [3:0]    avs_byteenable;
  logic          avs_read;
  logic [31:0]   avs_readdata;

  modport master (
    output avs_address,
    output avs_write,
    output avs_writedata,
    output avs_byteenable,
    output avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address,
    input  avs_write,
    input  avs_writedata,
    input  avs_byteenable,
    input  avs_read,
    output avs_readdata
  );

endinterface

// File: rtl/string_hw_wordbuf.sv
// MAX_BLOCKS-word byte buffer with a packed byte view.
//   clk, reset   clock, synchronous active-high reset (clears all bytes)
//   wr_en        word write; wr_word selects word k, wr_be masks lanes,
//                wr_data[7:0] lands in byte 4k, wr_data[31:24] in byte 4k+3
//   load_en      whole-buffer load from load_data (honoured only when
//                PARALLEL_LOAD=1; the shadow result buffer uses this)
//   bytes        current contents, byte 0 first
module string_hw_wordbuf #(
  parameter int unsigned MAX_BLOCKS    = 8,
  parameter bit          PARALLEL_LOAD = 1'b0,
  localparam int unsigned NB = MAX_BLOCKS * 4,
  localparam int unsigned WW = $clog2(MAX_BLOCKS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WW-1:0]          wr_word,
  input  logic [31:0]            wr_data,
  input  logic [3:0]             wr_be,
  input  logic                   load_en,
  input  logic [0:NB-1][7:0]     load_data,
  output logic [0:NB-1][7:0]     bytes
);

  always_ff @(posedge clk) begin
    if (reset) begin
      bytes <= '0;
    end else if (PARALLEL_LOAD && load_en) begin
      bytes <= load_data;
    end else if (wr_en) begin
      for (int unsigned l = 0; l < 4; l++) begin
        if (wr_be[l]) begin
          bytes[{wr_word, 2'(l)}] <= wr_data[8*l +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/string_hw_avalon_ctrl.sv
// Avalon-MM slave front end driving the string accelerator go/done handshake.
//   clk, reset       system clock, synchronous active-high reset (shared
//                    with the accelerator)
//   avs              Avalon-MM slave bus (read latency 1)
//   irq              level interrupt: IRQ_EN & (done | bad_index | timeout)
//   acc_go           accelerator go, high in ISSUE/CAPTURE
//   acc_index        function select (CMD[3:0])
//   acc_length       search length (CMD[15:8])
//   acc_A, acc_B     operand buffers, byte 0 first
//   acc_done         accelerator done
//   acc_result       accelerator result, copied into the R shadow buffer
// Word map: 0 CTRL (WO), 1 CMD, 2 STATUS (RO), 3 reads 0,
// then regions A, B, R (RO) of MAX_BLOCKS words each.
module string_hw_avalon_ctrl #(
  parameter int unsigned MAX_BLOCKS  = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                              clk,
  input  logic                              reset,
  string_hw_avalon_ctrl_if.slave            avs,
  output logic                              irq,
  output logic                              acc_go,
  output logic [3:0]                        acc_index,
  output logic [7:0]                        acc_length,
  output logic [0:MAX_BLOCKS*4-1][7:0]      acc_A,
  output logic [0:MAX_BLOCKS*4-1][7:0]      acc_B,
  input  logic                              acc_done,
  input  logic [0:MAX_BLOCKS*4-1][7:0]      acc_result
);

  import string_hw_pkg::*;

  localparam int unsigned AW = $clog2(MAX_BLOCKS) + 2;
  localparam int unsigned WW = AW - 2;
  localparam int unsigned NB = MAX_BLOCKS * 4;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

  state_t            state;
  logic [TW-1:0]     tcnt;
  logic [3:0]        cmd_index;
  logic [7:0]        cmd_length;
  logic              irq_en;
  logic              done_flag;
  logic              bad_index;
  logic              timeout_flag;
  logic [0:NB-1][7:0] res_shadow;

  region_t           rgn;
  logic [WW-1:0]     word;
  logic              busy;
  logic              wr_ctrl;
  logic              wr_cmd;
  logic              wr_a;
  logic              wr_b;
  logic              start_req;
  logic              clr_req;
  logic [31:0]       status;
  logic [31:0]       rdata_nxt;

  assign acc_index  = cmd_index;
  assign acc_length = cmd_length;

  // ---------------------------------------------------------------------
  // Address decode and write qualification
  // ---------------------------------------------------------------------
  always_comb begin
    rgn  = region_t'(avs.avs_address[AW-1 -: 2]);
    word = avs.avs_address[WW-1:0];
    busy = (state != ST_IDLE);

    wr_ctrl = avs.avs_write && (rgn == RGN_REGS) && (word == WW'(REG_CTRL))
              && avs.avs_byteenable[0];
    // Operands are frozen while a command is in flight
    wr_cmd  = avs.avs_write && (rgn == RGN_REGS) && (word == WW'(REG_CMD)) && !busy;
    wr_a    = avs.avs_write && (rgn == RGN_A) && !busy;
    wr_b    = avs.avs_write && (rgn == RGN_B) && !busy;

    start_req = wr_ctrl && avs.avs_writedata[CTRL_START] && !busy;
    clr_req   = wr_ctrl && avs.avs_writedata[CTRL_CLR];
  end

  // ---------------------------------------------------------------------
  // Buffers
  // ---------------------------------------------------------------------
  string_hw_wordbuf #(
    .MAX_BLOCKS    (MAX_BLOCKS),
    .PARALLEL_LOAD (1'b0)
  ) u_buf_a (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_a),
    .wr_word   (word),
    .wr_data   (avs.avs_writedata),
    .wr_be     (avs.avs_byteenable),
    .load_en   (1'b0),
    .load_data ('0),
    .bytes     (acc_A)
  );

  string_hw_wordbuf #(
    .MAX_BLOCKS    (MAX_BLOCKS),
    .PARALLEL_LOAD (1'b0)
  ) u_buf_b (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_b),
    .wr_word   (word),
    .wr_data   (avs.avs_writedata),
    .wr_be     (avs.avs_byteenable),
    .load_en   (1'b0),
    .load_data ('0),
    .bytes     (acc_B)
  );

  // Result shadow: loaded from acc_result during the single CAPTURE cycle
  string_hw_wordbuf #(
    .MAX_BLOCKS    (MAX_BLOCKS),
    .PARALLEL_LOAD (1'b1)
  ) u_buf_r (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (1'b0),
    .wr_word   ('0),
    .wr_data   ('0),
    .wr_be     ('0),
    .load_en   (state == ST_CAPTURE),
    .load_data (acc_result),
    .bytes     (res_shadow)
  );

  // ---------------------------------------------------------------------
  // Read mux (registered below, so a same-cycle write returns old data)
  // ---------------------------------------------------------------------
  always_comb begin
    status = '0;
    status[STAT_BUSY]      = busy;
    status[STAT_DONE]      = done_flag;
    status[STAT_BAD_INDEX] = bad_index;
    status[STAT_TIMEOUT]   = timeout_flag;

    rdata_nxt = '0;
    case (rgn)
      RGN_REGS: begin
        if (word == WW'(REG_CMD)) begin
          rdata_nxt = {16'h0000, cmd_length, 4'h0, cmd_index};
        end else if (word == WW'(REG_STATUS)) begin
          rdata_nxt = status;
        end
      end
      RGN_A: begin
        for (int unsigned l = 0; l < 4; l++) begin
          rdata_nxt[8*l +: 8] = acc_A[{word, 2'(l)}];
        end
      end
      RGN_B: begin
        for (int unsigned l = 0; l < 4; l++) begin
          rdata_nxt[8*l +: 8] = acc_B[{word, 2'(l)}];
        end
      end
      RGN_R: begin
        for (int unsigned l = 0; l < 4; l++) begin
          rdata_nxt[8*l +: 8] = res_shadow[{word, 2'(l)}];
        end
      end
      default: rdata_nxt = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Registers and command FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      tcnt             <= '0;
      cmd_index        <= '0;
      cmd_length       <= '0;
      irq_en           <= 1'b0;
      done_flag        <= 1'b0;
      bad_index        <= 1'b0;
      timeout_flag     <= 1'b0;
      acc_go           <= 1'b0;
      irq              <= 1'b0;
      avs.avs_readdata <= '0;
    end else begin
      if (avs.avs_read) begin
        avs.avs_readdata <= rdata_nxt;
      end

      irq <= irq_en & (done_flag | bad_index | timeout_flag);

      if (wr_ctrl) begin
        irq_en <= avs.avs_writedata[CTRL_IRQ_EN];
      end

      if (wr_cmd) begin
        if (avs.avs_byteenable[0]) cmd_index  <= avs.avs_writedata[3:0];
        if (avs.avs_byteenable[1]) cmd_length <= avs.avs_writedata[15:8];
      end

      // CLR is applied first; FSM flag updates below take precedence, which
      // gives CLR-then-START ordering for a combined CTRL write.
      if (clr_req) begin
        done_flag    <= 1'b0;
        bad_index    <= 1'b0;
        timeout_flag <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (start_req) begin
            if (cmd_index > MAX_FUNC) begin
              bad_index <= 1'b1;
            end else begin
              done_flag    <= 1'b0;
              bad_index    <= 1'b0;
              timeout_flag <= 1'b0;
              tcnt         <= '0;
              acc_go       <= 1'b1;
              state        <= ST_ISSUE;
            end
          end
        end

        ST_ISSUE: begin
          if (acc_done) begin
            state <= ST_CAPTURE;
          end else if (tcnt == TLAST) begin
            acc_go       <= 1'b0;
            timeout_flag <= 1'b1;
            state        <= ST_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        ST_CAPTURE: begin
          acc_go <= 1'b0;
          tcnt   <= '0;
          state  <= ST_RELEASE;
        end

        ST_RELEASE: begin
          if (!acc_done) begin
            done_flag <= 1'b1;
            state     <= ST_IDLE;
          end else if (tcnt == TLAST) begin
            timeout_flag <= 1'b1;
            state        <= ST_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        default: begin
          acc_go <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_string_hw_avalon_ctrl.sv
module tb_string_hw_avalon_ctrl;
  import string_hw_pkg::*;

  localparam int MB = 8;
  localparam int NB = MB * 4;
  localparam int TO = 255;
  localparam logic [4:0] A_BASE = 5'd8;
  localparam logic [4:0] B_BASE = 5'd16;
  localparam logic [4:0] R_BASE = 5'd24;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  string_hw_avalon_ctrl_if #(.AW(5)) bus ();

  logic               irq;
  logic               acc_go;
  logic [3:0]         acc_index;
  logic [7:0]         acc_length;
  logic [0:NB-1][7:0] acc_A;
  logic [0:NB-1][7:0] acc_B;
  logic               acc_done = 1'b0;
  logic [0:NB-1][7:0] acc_result = '0;

  string_hw_avalon_ctrl #(
    .MAX_BLOCKS  (MB),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .avs        (bus),
    .irq        (irq),
    .acc_go     (acc_go),
    .acc_index  (acc_index),
    .acc_length (acc_length),
    .acc_A      (acc_A),
    .acc_B      (acc_B),
    .acc_done   (acc_done),
    .acc_result (acc_result)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- accelerator model ----------------
  // UPPER converts only the first `len` bytes; SEARCH reports the first
  // match position in the last byte (NOT_FOUND truncates to 0 there).
  function automatic logic [0:NB-1][7:0] model(input logic [3:0] idx,
      input logic [7:0] len, input logic [0:NB-1][7:0] a,
      input logic [0:NB-1][7:0] b);
    logic [0:NB-1][7:0] r;
    int pos;
    bit ok;
    r = '0;
    pos = NOT_FOUND;
    case (idx)
      4'd0: r[NB-1] = (a == b) ? 8'd1 : 8'd0;
      4'd1: begin
        r = a;
        for (int i = 0; i < NB; i++)
          if (i < int'(len) && a[i] >= 8'h61 && a[i] <= 8'h7A) r[i] = a[i] - 8'd32;
      end
      4'd4: begin
        for (int p = 0; p + int'(len) <= NB; p++) begin
          ok = 1'b1;
          for (int k = 0; k < int'(len); k++)
            if (a[p+k] != b[k]) ok = 1'b0;
          if (ok && pos == NOT_FOUND) pos = p;
        end
        r[NB-1] = pos[7:0];
      end
      default: r = a;
    endcase
    return r;
  endfunction

  bit model_stall = 1'b0;
  int dly = 0;

  always @(negedge clk) begin
    if (reset) begin
      acc_done = 1'b0;
      acc_result = '0;
      dly = 0;
    end else if (acc_go && !acc_done && !model_stall) begin
      dly++;
      if (dly >= 3) begin
        acc_result = model(acc_index, acc_length, acc_A, acc_B);
        acc_done = 1'b1;
        dly = 0;
      end
    end else if (!acc_go && acc_done) begin
      dly++;
      if (dly >= 2) begin
        acc_done = 1'b0;
        dly = 0;
      end
    end else begin
      dly = 0;
    end
  end

  // ---------------- bus tasks ----------------
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    bus.avs_address = a;
    bus.avs_writedata = d;
    bus.avs_byteenable = be;
    bus.avs_write = 1'b1;
    @(negedge clk);
    bus.avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.avs_address = a;
    bus.avs_read = 1'b1;
    @(negedge clk);
    bus.avs_read = 1'b0;
    d = bus.avs_readdata;
  endtask

  task automatic fill(input logic [4:0] base, input logic [31:0] w0, input logic [31:0] w1);
    bus_write(base, w0, 4'hF);
    bus_write(5'(base + 5'd1), w1, 4'hF);
    for (int k = 2; k < MB; k++) bus_write(5'(base + 5'(k)), 32'h0, 4'hF);
  endtask

  // Polls STATUS until busy clears; ok=0 if the bound expires.
  task automatic wait_idle(output bit ok);
    logic [31:0] s;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bus_read(5'd2, s);
      if (!s[0]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b expected 0", irq); end
    n_cmp++;
    if (acc_go !== 1'b0) begin n_bad++; $display("FAIL reset_go: got %b expected 0", acc_go); end
    for (int i = 0; i < 4 * MB; i++) begin
      bus_read(5'(i), d);
      n_cmp++;
      if (d !== 32'h0) begin n_bad++; $display("FAIL reset_read[%0d]: got %h expected 00000000", i, d); end
    end
  endtask

  task automatic test_cmd_regs();
    logic [31:0] d;
    bus_write(5'd1, 32'h0000_0503, 4'hF);
    bus_read(5'd1, d);
    n_cmp++;
    if (d !== 32'h0000_0503) begin n_bad++; $display("FAIL cmd_rw: got %h expected 00000503", d); end
    bus_write(5'd1, 32'hFFFF_0700, 4'b0010);
    bus_read(5'd1, d);
    n_cmp++;
    if (d !== 32'h0000_0703) begin n_bad++; $display("FAIL cmd_be: got %h expected 00000703", d); end
    bus_write(5'd1, 32'hFFFF_FFFF, 4'hF);
    bus_read(5'd1, d);
    n_cmp++;
    if (d !== 32'h0000_FF0F) begin n_bad++; $display("FAIL cmd_mask: got %h expected 0000ff0f", d); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d;
    bus_write(5'(A_BASE + 5'd2), 32'hAABB_CCDD, 4'b0101);
    bus_read(5'(A_BASE + 5'd2), d);
    n_cmp++;
    if (d !== 32'h00BB_00DD) begin n_bad++; $display("FAIL lane_read: got %h expected 00bb00dd", d); end
    n_cmp++;
    if ({acc_A[11], acc_A[10], acc_A[9], acc_A[8]} !== 32'h00BB_00DD) begin
      n_bad++;
      $display("FAIL lane_bytes: got %h expected 00bb00dd", {acc_A[11], acc_A[10], acc_A[9], acc_A[8]});
    end
    bus_write(R_BASE, 32'hFFFF_FFFF, 4'hF);
    bus_read(R_BASE, d);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL r_ro: got %h expected 00000000", d); end
    bus_write(5'd3, 32'hFFFF_FFFF, 4'hF);
    bus_read(5'd3, d);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL rsvd: got %h expected 00000000", d); end
    // simultaneous read and write of A word 3
    @(negedge clk);
    bus.avs_address = 5'(A_BASE + 5'd3);
    bus.avs_writedata = 32'h1234_5678;
    bus.avs_byteenable = 4'hF;
    bus.avs_write = 1'b1;
    bus.avs_read = 1'b1;
    @(negedge clk);
    bus.avs_write = 1'b0;
    bus.avs_read = 1'b0;
    n_cmp++;
    if (bus.avs_readdata !== 32'h0) begin n_bad++; $display("FAIL rw_same: got %h expected 00000000", bus.avs_readdata); end
    bus_read(5'(A_BASE + 5'd3), d);
    n_cmp++;
    if (d !== 32'h1234_5678) begin n_bad++; $display("FAIL rw_after: got %h expected 12345678", d); end
  endtask

  task automatic test_upper();
    logic [31:0] d;
    bit ok;
    fill(A_BASE, 32'h6463_6261, 32'h4847_4645);  // "abcd" "EFGH"
    bus_write(5'd1, 32'h0000_0301, 4'hF);         // UPPER, length 3
    bus_write(5'd0, 32'h1, 4'hF);
    n_cmp++;
    if (acc_go !== 1'b1) begin n_bad++; $display("FAIL upper_go_rise: got %b expected 1", acc_go); end
    n_cmp++;
    if (acc_length !== 8'd3) begin n_bad++; $display("FAIL upper_len: got %h expected 03", acc_length); end
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL upper_idle: got busy expected idle"); end
    n_cmp++;
    if (acc_go !== 1'b0) begin n_bad++; $display("FAIL upper_go_fall: got %b expected 0", acc_go); end
    bus_read(R_BASE, d);
    n_cmp++;
    if (d !== 32'h6443_4241) begin n_bad++; $display("FAIL upper_r0: got %h expected 64434241", d); end
    bus_read(5'(R_BASE + 5'd1), d);
    n_cmp++;
    if (d !== 32'h4847_4645) begin n_bad++; $display("FAIL upper_r1: got %h expected 48474645", d); end
    bus_read(5'd2, d);
    n_cmp++;
    if (d !== 32'h2) begin n_bad++; $display("FAIL upper_status: got %h expected 00000002", d); end
  endtask

  task automatic test_cmp_irq();
    logic [31:0] d;
    bit ok;
    fill(A_BASE, 32'h1122_3344, 32'h5566_7788);
    fill(B_BASE, 32'h1122_3344, 32'h5566_7788);
    bus_write(5'd1, 32'h0, 4'hF);
    bus_write(5'd0, 32'h3, 4'hF);  // IRQ_EN | START
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL cmp_idle: got busy expected idle"); end
    for (int i = 0; i < MB; i++) begin
      bus_read(5'(R_BASE + 5'(i)), d);
      n_cmp++;
      if (d !== ((i == MB - 1) ? 32'h0100_0000 : 32'h0)) begin
        n_bad++;
        $display("FAIL cmp_r[%0d]: got %h expected %h", i, d, (i == MB - 1) ? 32'h0100_0000 : 32'h0);
      end
    end
    n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL cmp_irq: got %b expected 1", irq); end
    bus_write(5'd0, 32'h6, 4'hF);  // CLR, keep IRQ_EN
    repeat (2) @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL clr_irq: got %b expected 0", irq); end
    bus_read(5'd2, d);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL clr_status: got %h expected 00000000", d); end
  endtask

  task automatic test_bad_index();
    logic [31:0] d;
    bit saw;
    saw = 1'b0;
    bus_write(5'd1, 32'h5, 4'hF);
    bus_write(5'd0, 32'h3, 4'hF);
    for (int i = 0; i < 20; i++) begin
      if (acc_go) saw = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (saw !== 1'b0) begin n_bad++; $display("FAIL bad_go: got %b expected 0", saw); end
    bus_read(5'd2, d);
    n_cmp++;
    if (d !== 32'h4) begin n_bad++; $display("FAIL bad_status: got %h expected 00000004", d); end
    n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL bad_irq: got %b expected 1", irq); end
    bus_write(5'd0, 32'h4, 4'hF);  // CLR, IRQ_EN off
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    int cnt;
    model_stall = 1'b1;
    bus_write(5'd1, 32'h2, 4'hF);
    bus_write(5'd0, 32'h1, 4'hF);
    cnt = 0;
    while (acc_go && cnt < 1000) begin
      cnt++;
      if (cnt == 1) begin
        bus.avs_address = A_BASE;
        bus.avs_writedata = 32'hDEAD_BEEF;
        bus.avs_byteenable = 4'hF;
        bus.avs_write = 1'b1;
      end else if (cnt == 2) begin
        bus.avs_write = 1'b0;
      end
      @(negedge clk);
    end
    bus.avs_write = 1'b0;
    model_stall = 1'b0;
    n_cmp++;
    if (cnt != TO) begin n_bad++; $display("FAIL to_go_cycles: got %0d expected %0d", cnt, TO); end
    n_cmp++;
    if ({acc_A[3], acc_A[2], acc_A[1], acc_A[0]} !== 32'h1122_3344) begin
      n_bad++;
      $display("FAIL to_acc_a: got %h expected 11223344", {acc_A[3], acc_A[2], acc_A[1], acc_A[0]});
    end
    bus_read(5'd2, d);
    n_cmp++;
    if (d !== 32'h8) begin n_bad++; $display("FAIL to_status: got %h expected 00000008", d); end
  endtask

  task automatic test_search_reset();
    logic [31:0] d;
    bit ok;
    fill(A_BASE, 32'h6568_7878, 32'h006F_6C6C);  // "xxhello"
    fill(B_BASE, 32'h6C6C_6568, 32'h0000_006F);  // "hello"
    bus_write(5'd1, 32'h0000_0504, 4'hF);        // SEARCH, length 5
    bus_write(5'd0, 32'h1, 4'hF);
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL search_idle: got busy expected idle"); end
    for (int i = 0; i < MB; i++) begin
      bus_read(5'(R_BASE + 5'(i)), d);
      n_cmp++;
      if (d !== ((i == MB - 1) ? 32'h0200_0000 : 32'h0)) begin
        n_bad++;
        $display("FAIL search_r[%0d]: got %h expected %h", i, d, (i == MB - 1) ? 32'h0200_0000 : 32'h0);
      end
    end
    // restart, then reset while in ISSUE
    bus_write(5'd0, 32'h1, 4'hF);
    n_cmp++;
    if (acc_go !== 1'b1) begin n_bad++; $display("FAIL rst_go_before: got %b expected 1", acc_go); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (acc_go !== 1'b0) begin n_bad++; $display("FAIL rst_go_after: got %b expected 0", acc_go); end
    @(negedge clk);
    reset = 1'b0;
    bus_read(5'd2, d);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL rst_status: got %h expected 00000000", d); end
    bus_read(5'd1, d);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL rst_cmd: got %h expected 00000000", d); end
    bus_read(A_BASE, d);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL rst_a0: got %h expected 00000000", d); end
  endtask

  initial begin
    bus.avs_address = '0;
    bus.avs_write = 1'b0;
    bus.avs_writedata = '0;
    bus.avs_byteenable = '0;
    bus.avs_read = 1'b0;
    test_reset();
    test_cmd_regs();
    test_byte_lanes();
    test_upper();
    test_cmp_irq();
    test_bad_index();
    test_timeout();
    test_search_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
